// File: rtl/ows_pkg.sv
// Shared definitions for the 1-wire ROM command decoder: FSM states,
// ROM command codes, widths and the default device ROM code.
package ows_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ROM_W  = 64;
    localparam int unsigned CNT_W  = 3;

    localparam logic [BYTE_W-1:0] ROM_CMD_MATCH = 8'h55;
    localparam logic [BYTE_W-1:0] ROM_CMD_SKIP  = 8'hCC;

    localparam logic [ROM_W-1:0] ROM_ID_DEFAULT = 64'hA200000B1C3D4E28;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ROM_CMD,
        ST_MATCH,
        ST_FUNC_CMD,
        ST_PAYLOAD,
        ST_DESELECT
    } ows_state_t;

endpackage

// File: rtl/ows_rom_decoder_if.sv
// Byte-level link between the 1-wire receiver (master) and the ROM decoder (slave).
interface ows_rom_decoder_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  bus_reset;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_write;
    logic                  selected;
    logic [7:0]            func_cmd;
    logic                  func_valid;
    logic [7:0]            payload_data;
    logic                  payload_valid;
    logic                  rom_err;

    modport master (
        output bus_reset, rx_data, rx_write,
        input  selected, func_cmd, func_valid, payload_data, payload_valid, rom_err
    );

    modport slave (
        input  bus_reset, rx_data, rx_write,
        output selected, func_cmd, func_valid, payload_data, payload_valid, rom_err
    );
endinterface

// File: rtl/ows_rom_decoder.sv
// 1-wire ROM command decoder: tracks Match ROM / Skip ROM after each bus
// reset, then forwards the function command and payload bytes.
// Optional feature: define OWS_SKIP_ROM_EN to let 0xCC (Skip ROM) select
// the device; by default 0xCC is reported as an unsupported ROM command.
module ows_rom_decoder
    import ows_pkg::*;
#(
    parameter int unsigned      DATA_WIDTH = 8,
    parameter logic [ROM_W-1:0] ROM_ID     = ROM_ID_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    ows_rom_decoder_if.slave  bus
);

`ifdef OWS_SKIP_ROM_EN
    localparam bit SKIP_ROM_EN = 1'b1;
`else
    localparam bit SKIP_ROM_EN = 1'b0;
`endif

    ows_state_t         state;
    logic [CNT_W-1:0]   byte_cnt;
    logic               selected_q;
    logic [BYTE_W-1:0]  func_cmd_q;
    logic               func_valid_q;
    logic [BYTE_W-1:0]  payload_data_q;
    logic               payload_valid_q;
    logic               rom_err_q;

    logic [DATA_WIDTH-1:0] rx_word;
    logic [BYTE_W-1:0]     rx_byte;
    logic [BYTE_W-1:0]     rom_byte;

    // Received byte and the ROM code byte currently expected in MATCH
    assign rx_word  = bus.rx_data;
    assign rx_byte  = rx_word[BYTE_W-1:0];
    assign rom_byte = ROM_ID[{byte_cnt, 3'b000} +: BYTE_W];

    // Decoder FSM with registered outputs; bus_reset overrides any byte
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            byte_cnt        <= '0;
            selected_q      <= 1'b0;
            func_cmd_q      <= '0;
            func_valid_q    <= 1'b0;
            payload_data_q  <= '0;
            payload_valid_q <= 1'b0;
            rom_err_q       <= 1'b0;
        end else begin
            func_valid_q    <= 1'b0;
            payload_valid_q <= 1'b0;
            rom_err_q       <= 1'b0;
            if (bus.bus_reset) begin
                state      <= ST_ROM_CMD;
                byte_cnt   <= '0;
                selected_q <= 1'b0;
            end else if (bus.rx_write) begin
                unique case (state)
                    ST_ROM_CMD: begin
                        if (rx_byte == ROM_CMD_MATCH) begin
                            state    <= ST_MATCH;
                            byte_cnt <= '0;
                        end else if (SKIP_ROM_EN && (rx_byte == ROM_CMD_SKIP)) begin
                            state      <= ST_FUNC_CMD;
                            selected_q <= 1'b1;
                        end else begin
                            state     <= ST_DESELECT;
                            rom_err_q <= 1'b1;
                        end
                    end
                    ST_MATCH: begin
                        if (rx_byte != rom_byte) begin
                            state     <= ST_DESELECT;
                            byte_cnt  <= '0;
                            rom_err_q <= 1'b1;
                        end else if (byte_cnt == CNT_W'(7)) begin
                            // Last ROM byte matched: leave MATCH rather than wrap
                            state      <= ST_FUNC_CMD;
                            byte_cnt   <= '0;
                            selected_q <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + CNT_W'(1);
                        end
                    end
                    ST_FUNC_CMD: begin
                        func_cmd_q   <= rx_byte;
                        func_valid_q <= 1'b1;
                        state        <= ST_PAYLOAD;
                    end
                    ST_PAYLOAD: begin
                        payload_data_q  <= rx_byte;
                        payload_valid_q <= 1'b1;
                    end
                    ST_DESELECT: begin
                        selected_q <= 1'b0;
                    end
                    ST_IDLE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Drive the registered results onto the interface
    assign bus.selected      = selected_q;
    assign bus.func_cmd      = func_cmd_q;
    assign bus.func_valid    = func_valid_q;
    assign bus.payload_data  = payload_data_q;
    assign bus.payload_valid = payload_valid_q;
    assign bus.rom_err       = rom_err_q;

endmodule
